// File: rtl/pc_ctrl.sv
// PC / pipeline sequencing controller: merges jump, interrupt, stall and JTAG
// halt/reset requests into registered controls for pc_reg and the pipeline regs.
module pc_ctrl #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned HOLD_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_jump_i,
   input  logic [ADDR_W-1:0] ex_jump_addr_i,
   input  logic              int_assert_i,
   input  logic [ADDR_W-1:0] int_addr_i,
   input  logic              ex_hold_i,
   input  logic              rib_hold_i,
   input  logic              jtag_halt_i,
   input  logic              jtag_reset_i,
   output logic              jump_flag_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic [HOLD_W-1:0] hold_flag_o,
   output logic              jtag_reset_flag_o,
   output logic              halted_o
);

   localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_NONE = HOLD_W'(0);
   localparam logic [HOLD_W-1:0] HOLD_PC   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_ID   = HOLD_W'(3);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT,
      ST_RESET
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [HOLD_W-1:0]  w_src_hold;
   logic               w_redirect;

   // Highest requested level wins; ex_hold (ID) dominates rib_hold (PC).
   always_comb begin
      w_src_hold = HOLD_NONE;
      if (rib_hold_i) w_src_hold = HOLD_PC;
      if (ex_hold_i)  w_src_hold = HOLD_ID;
   end

   assign w_redirect = int_assert_i | ex_jump_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state           <= ST_RUN;
         r_cnt             <= '0;
         jump_flag_o       <= 1'b0;
         jump_addr_o       <= '0;
         hold_flag_o       <= HOLD_NONE;
         jtag_reset_flag_o <= 1'b0;
         halted_o          <= 1'b0;
      end else begin
         jump_flag_o <= 1'b0;
         if (jtag_reset_i) begin
            r_state           <= ST_RESET;
            r_cnt             <= CNT_W'(RST_CYCLES - 1);
            jtag_reset_flag_o <= 1'b1;
            hold_flag_o       <= HOLD_ID;
            halted_o          <= 1'b0;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (int_assert_i) begin
                     jump_flag_o <= 1'b1;
                     jump_addr_o <= int_addr_i;
                  end else if (ex_jump_i) begin
                     jump_flag_o <= 1'b1;
                     jump_addr_o <= ex_jump_addr_i;
                  end
                  // A redirect in the same cycle defers the halt to a later sample.
                  if (jtag_halt_i && !w_redirect) begin
                     r_state     <= ST_HALT;
                     halted_o    <= 1'b1;
                     hold_flag_o <= HOLD_ID;
                  end else begin
                     hold_flag_o <= w_src_hold;
                  end
               end
               ST_HALT: begin
                  if (!jtag_halt_i) begin
                     r_state     <= ST_RUN;
                     halted_o    <= 1'b0;
                     hold_flag_o <= w_src_hold;
                  end else begin
                     hold_flag_o <= HOLD_ID;
                  end
               end
               ST_RESET: begin
                  if (r_cnt == '0) begin
                     jtag_reset_flag_o <= 1'b0;
                     if (jtag_halt_i) begin
                        r_state     <= ST_HALT;
                        halted_o    <= 1'b1;
                        hold_flag_o <= HOLD_ID;
                     end else begin
                        r_state     <= ST_RUN;
                        hold_flag_o <= w_src_hold;
                     end
                  end else begin
                     r_cnt       <= r_cnt - 1'b1;
                     hold_flag_o <= HOLD_ID;
                  end
               end
               default: begin
                  r_state     <= ST_RUN;
                  hold_flag_o <= HOLD_NONE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed + randomized bench for pc_ctrl against a cycle-level behavioural model.
module tb_pc_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned RC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_jump_i, int_assert_i, ex_hold_i, rib_hold_i, jtag_halt_i, jtag_reset_i;
   logic [AW-1:0] ex_jump_addr_i, int_addr_i;
   logic          jump_flag_o, jtag_reset_flag_o, halted_o;
   logic [AW-1:0] jump_addr_o;
   logic [2:0]    hold_flag_o;

   int tests = 0;
   int fails = 0;

   // Model: mode 0=running, 1=halted, 2=reset pulse; m_left = pulse cycles remaining.
   int            m_mode;
   int            m_left;
   logic          m_jf, m_rf, m_halted;
   logic [AW-1:0] m_ja;
   logic [2:0]    m_hold;

   pc_ctrl #(.ADDR_W(AW), .RST_CYCLES(RC), .HOLD_W(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .ex_jump_i         (ex_jump_i),
      .ex_jump_addr_i    (ex_jump_addr_i),
      .int_assert_i      (int_assert_i),
      .int_addr_i        (int_addr_i),
      .ex_hold_i         (ex_hold_i),
      .rib_hold_i        (rib_hold_i),
      .jtag_halt_i       (jtag_halt_i),
      .jtag_reset_i      (jtag_reset_i),
      .jump_flag_o       (jump_flag_o),
      .jump_addr_o       (jump_addr_o),
      .hold_flag_o       (hold_flag_o),
      .jtag_reset_flag_o (jtag_reset_flag_o),
      .halted_o          (halted_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("jump_flag", AW'(jump_flag_o), AW'(m_jf));
      chk("jump_addr", jump_addr_o, m_ja);
      chk("hold_flag", AW'(hold_flag_o), AW'(m_hold));
      chk("jtag_reset_flag", AW'(jtag_reset_flag_o), AW'(m_rf));
      chk("halted", AW'(halted_o), AW'(m_halted));
   endtask

   task automatic model_reset();
      m_mode = 0; m_left = 0;
      m_jf = 0; m_ja = '0; m_hold = 0; m_rf = 0; m_halted = 0;
   endtask

   task automatic model_edge(input logic jr, input logic ia, input logic ej, input logic eh,
                             input logic rh, input logic jh,
                             input logic [AW-1:0] iaddr, input logic [AW-1:0] eaddr);
      logic [2:0] src;
      src = eh ? 3'd3 : (rh ? 3'd1 : 3'd0);
      m_jf = 0;
      if (jr) begin
         m_mode = 2; m_left = RC; m_rf = 1; m_hold = 3; m_halted = 0;
      end else if (m_mode == 2) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_rf = 0; m_mode = jh ? 1 : 0; m_halted = jh; m_hold = jh ? 3'd3 : src;
         end else begin
            m_hold = 3;
         end
      end else if (m_mode == 1) begin
         if (!jh) begin
            m_mode = 0; m_halted = 0; m_hold = src;
         end else begin
            m_hold = 3;
         end
      end else begin
         if (ia || ej) begin
            m_jf = 1; m_ja = ia ? iaddr : eaddr;
         end
         if (jh && !(ia || ej)) begin
            m_mode = 1; m_halted = 1; m_hold = 3;
         end else begin
            m_hold = src;
         end
      end
   endtask

   task automatic step();
      logic jr, ia, ej, eh, rh, jh;
      logic [AW-1:0] iaddr, eaddr;
      jr = jtag_reset_i; ia = int_assert_i; ej = ex_jump_i;
      eh = ex_hold_i; rh = rib_hold_i; jh = jtag_halt_i;
      iaddr = int_addr_i; eaddr = ex_jump_addr_i;
      @(posedge clk);
      model_edge(jr, ia, ej, eh, rh, jh, iaddr, eaddr);
      #1;
      check_all();
   endtask

   task automatic clear_inputs();
      ex_jump_i = 0; int_assert_i = 0; ex_hold_i = 0; rib_hold_i = 0;
      jtag_halt_i = 0; jtag_reset_i = 0; ex_jump_addr_i = '0; int_addr_i = '0;
   endtask

   // Called just after a sampled edge: drops rst mid-cycle, then releases it before the next edge.
   task automatic async_reset();
      #2 rst = 1'b0;
      #1 model_reset();
      check_all();
      #2 rst = 1'b1;
   endtask

   initial begin
      int cnt;
      rst = 1'b0;
      clear_inputs();
      model_reset();
      #12 rst = 1'b1;
      #1 check_all();

      // Jump with bus hold in the same cycle, then pulse ends.
      ex_jump_i = 1; ex_jump_addr_i = 32'h0000_0100; rib_hold_i = 1;
      step();
      chk("jump_pulse", AW'(jump_flag_o), AW'(1'b1));
      chk("jump_target", jump_addr_o, 32'h0000_0100);
      clear_inputs();
      step();
      chk("jump_addr_held", jump_addr_o, 32'h0000_0100);

      // Interrupt beats a simultaneous EX jump.
      int_assert_i = 1; int_addr_i = 32'h0000_0040; ex_jump_i = 1; ex_jump_addr_i = 32'h0000_0100;
      step();
      chk("int_wins", jump_addr_o, 32'h0000_0040);
      clear_inputs();
      step();

      // Stacked holds.
      ex_hold_i = 1; rib_hold_i = 1;
      step(); step(); step();
      ex_hold_i = 0;
      step();
      chk("hold_pc_only", AW'(hold_flag_o), AW'(3'd1));
      rib_hold_i = 0;
      step();

      // Halt, ignored jump, release.
      jtag_halt_i = 1;
      step();
      ex_jump_i = 1; ex_jump_addr_i = 32'hDEAD_BEE0;
      step();
      chk("halt_ignores_jump", AW'(jump_flag_o), AW'(1'b0));
      ex_jump_i = 0;
      step();
      async_reset();
      jtag_halt_i = 1;
      step();
      jtag_halt_i = 0;
      step();
      step();

      // Single JTAG reset pulse.
      cnt = 0;
      jtag_reset_i = 1;
      step();
      jtag_reset_i = 0;
      if (jtag_reset_flag_o) cnt++;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!jtag_reset_flag_o) break;
         cnt++;
      end
      chk("pulse_len", AW'(cnt), AW'(RC));

      // Extended pulse, halt held at the end.
      cnt = 0;
      jtag_reset_i = 1; step(); if (jtag_reset_flag_o) cnt++;
      jtag_reset_i = 0; step(); if (jtag_reset_flag_o) cnt++;
      jtag_reset_i = 1; step(); if (jtag_reset_flag_o) cnt++;
      jtag_reset_i = 0; jtag_halt_i = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!jtag_reset_flag_o) break;
         cnt++;
      end
      chk("pulse_ext_len", AW'(cnt), AW'(RC + 2));
      chk("halt_after_reset", AW'(halted_o), AW'(1'b1));
      jtag_halt_i = 0;
      step();

      // Randomized phase.
      for (int n = 0; n < 600; n++) begin
         jtag_reset_i   = ($urandom_range(0, 39) == 0);
         int_assert_i   = ($urandom_range(0, 7) == 0);
         ex_jump_i      = ($urandom_range(0, 4) == 0);
         ex_hold_i      = ($urandom_range(0, 3) == 0);
         rib_hold_i     = ($urandom_range(0, 2) == 0);
         int_addr_i     = $urandom;
         ex_jump_addr_i = $urandom;
         if ($urandom_range(0, 9) == 0) jtag_halt_i = ~jtag_halt_i;
         step();
         if ($urandom_range(0, 99) == 0) async_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
